acs_scheduler: RTL and testbench

ACS_SCHEDULER -- requirements
Module: acs_scheduler

---
 rtl/acs_scheduler.sv | 153 +++++++++++++++
 tb/tb_acs_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/acs_scheduler.sv
// acs_scheduler
//   Add-compare-select scheduler for a K=3 (g1=7, g2=5) Viterbi decoder
//   with 4 trellis states. It accepts one hard-decision symbol and then
//   runs the four ACS operations one after another (one next-state per
//   cycle). It then normalizes the surviving path metrics and emits the
//   decision word. Each symbol occupies 7 cycles: IDLE, 4 x ACS, NORM, OUT.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_sym_valid    received symbol valid
//   i_sym          received hard bits {r1,r2}
//   o_sym_ready    symbol accepted when high together with i_sym_valid
//   o_dec_valid    one-cycle pulse, o_dec holds a fresh decision word
//   o_dec          survivor decision per next-state (1 = odd predecessor won)
//   o_best_state   lowest-index state with the smallest metric
//   o_pm           normalized path metrics, state n at [n*W_PM +: W_PM]
//   o_busy         high whenever the scheduler is not idle
module acs_scheduler #(
  parameter int W_PM = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sym_valid,
  input  logic [1:0]          i_sym,
  output logic                o_sym_ready,
  output logic                o_dec_valid,
  output logic [3:0]          o_dec,
  output logic [1:0]          o_best_state,
  output logic [4*W_PM-1:0]   o_pm,
  output logic                o_busy
);

  localparam logic [W_PM-1:0]   PM_MAX = '1;
  // Only state 0 is a legal start: the others begin at the ceiling.
  localparam logic [4*W_PM-1:0] PM_RST = {{3{PM_MAX}}, {W_PM{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACS, NORM, OUT} state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic [1:0]      sym_q;
  logic [W_PM-1:0] shadow [4];
  logic [3:0]      dec_q;

  // Hamming distance between the expected and the received code pair.
  function automatic logic [1:0] branch_metric(input logic [1:0] code,
                                               input logic [1:0] rx);
    logic [1:0] d;
    d = code ^ rx;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  // Metric add that clamps at the ceiling instead of wrapping.
  function automatic logic [W_PM-1:0] sat_add(input logic [W_PM-1:0] pm,
                                               input logic [1:0]      bm);
    logic [W_PM+1:0] s;
    s = {2'b00, pm} + {{W_PM{1'b0}}, bm};
    if (s > {2'b00, PM_MAX}) return PM_MAX;
    return s[W_PM-1:0];
  endfunction

  logic [W_PM-1:0] pm_a [4];
  logic            u, b0;
  logic [1:0]      code0, code1;
  logic [W_PM-1:0] cand0, cand1, win;
  logic            pick1;
  logic [W_PM-1:0] mn;
  logic [1:0]      best;

  // ACS for next-state ns = cnt. The predecessors are {ns[0],0} and
  // {ns[0],1}, and the input bit is ns[1]. Candidates read o_pm, which
  // is only rewritten in NORM, so every ACS of a symbol sees the old metrics.
  always_comb begin
    for (int i = 0; i < 4; i++) pm_a[i] = o_pm[i*W_PM +: W_PM];
    u     = cnt[1];
    b0    = cnt[0];
    code0 = {u ^ b0, u};
    code1 = {u ^ b0 ^ 1'b1, ~u};
    cand0 = sat_add(pm_a[{b0, 1'b0}], branch_metric(code0, sym_q));
    cand1 = sat_add(pm_a[{b0, 1'b1}], branch_metric(code1, sym_q));
    pick1 = (cand1 < cand0);
    win   = pick1 ? cand1 : cand0;
  end

  // Minimum of the shadow metrics; a strict compare keeps the lowest index on ties.
  always_comb begin
    mn   = shadow[0];
    best = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (shadow[i] < mn) begin
        mn   = shadow[i];
        best = 2'(i);
      end
    end
  end

  // Control and committed outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      o_pm         <= PM_RST;
      o_dec        <= '0;
      o_dec_valid  <= 1'b0;
      o_best_state <= '0;
      o_busy       <= 1'b0;
      o_sym_ready  <= 1'b0;
    end else begin
      o_dec_valid <= 1'b0;
      case (state)
        IDLE: begin
          o_sym_ready <= 1'b1;
          o_busy      <= 1'b0;
          if (i_sym_valid && o_sym_ready) begin
            cnt         <= '0;
            state       <= ACS;
            o_sym_ready <= 1'b0;
            o_busy      <= 1'b1;
          end
        end
        ACS: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= NORM;
        end
        NORM: begin
          for (int i = 0; i < 4; i++) o_pm[i*W_PM +: W_PM] <= shadow[i] - mn;
          o_best_state <= best;
          state        <= OUT;
        end
        OUT: begin
          o_dec       <= dec_q;
          o_dec_valid <= 1'b1;
          o_sym_ready <= 1'b1;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath working registers. They need no reset: every value is
  // rewritten before it is used.
  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_sym_valid && o_sym_ready) sym_q <= i_sym;
    if (state == ACS) begin
      shadow[cnt] <= win;
      dec_q[cnt]  <= pick1;
    end
  end

endmodule

// File: tb/tb_acs_scheduler.sv
// tb_acs_scheduler
//   Directed bench for acs_scheduler (W_PM=2). Expected decision words,
//   metrics and best states are hand-derived from the K=3 (7,5) trellis.
//   Metrics are packed as {s3,s2,s1,s0}, 2 bits each.
module tb_acs_scheduler;
  localparam int W_PM = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sym_valid = 1'b0;
  logic [1:0]       sym = 2'b00;
  logic             sym_ready, dec_valid, busy;
  logic [3:0]       dec;
  logic [1:0]       best_state;
  logic [4*W_PM-1:0] pm;

  acs_scheduler #(.W_PM(W_PM)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sym_valid (sym_valid),
    .i_sym       (sym),
    .o_sym_ready (sym_ready),
    .o_dec_valid (dec_valid),
    .o_dec       (dec),
    .o_best_state(best_state),
    .o_pm        (pm),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pulses = 0;
  always @(negedge clk) if (dec_valid) pulses++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input bit check_vals);
    rst_n = 1'b0;
    sym_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check_vals) begin
      chk("rst_pm", pm, 8'hFC);
      chk("rst_dec", dec, 4'h0);
      chk("rst_dec_valid", dec_valid, 1'b0);
      chk("rst_best", best_state, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", sym_ready, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Send one symbol once ready, then check the latency and the results.
  task automatic run_sym(input logic [1:0] s, input logic [3:0] edec,
                         input logic [7:0] epm, input logic [1:0] ebest,
                         input string tag, output int pcyc);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!sym_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, sym_ready, 1'b1);
    sym_valid = 1'b1;
    sym = s;
    @(posedge clk);
    #1 sym_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (dec_valid) break;
    end
    pcyc = cyc;
    chk({tag, "_latency"}, lat, 6);
    chk({tag, "_dec"}, dec, edec);
    chk({tag, "_pm"}, pm, epm);
    chk({tag, "_best"}, best_state, ebest);
  endtask

  // Eight consecutive 11 symbols from reset.
  logic [3:0] seq_dec  [8] = '{4'b0000, 4'b0000, 4'b1011, 4'b1011,
                               4'b0001, 4'b0001, 4'b0001, 4'b0001};
  logic [7:0] seq_pm   [8] = '{8'hCE, 8'h12, 8'h64, 8'h89,
                               8'h01, 8'h54, 8'h89, 8'h01};
  logic [1:0] seq_best [8] = '{2'd2, 2'd1, 2'd0, 2'd2,
                               2'd1, 2'd0, 2'd2, 2'd1};

  initial begin
    int pc, prev, p0, acc, bad, n;

    // Reset values and ready after release.
    do_reset(1'b1);
    @(posedge clk);
    #1;
    chk("ready_after_release", sym_ready, 1'b1);

    // A single 00 symbol.
    run_sym(2'b00, 4'b0000, 8'hEC, 2'd0, "sym00", pc);

    // Symbols 11 then 10: the encoder path ends in state 1.
    do_reset(1'b0);
    run_sym(2'b11, 4'b0000, 8'hCE, 2'd2, "sym11", pc);
    run_sym(2'b10, 4'b0000, 8'hB3, 2'd1, "sym10", pc);

    // Eight 11 symbols back to back: check the values, spacing and pulse count.
    do_reset(1'b0);
    p0 = pulses;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      run_sym(2'b11, seq_dec[i], seq_pm[i], seq_best[i], $sformatf("seq%0d", i), pc);
      if (i > 0) chk($sformatf("seq%0d_spacing", i), pc - prev, 7);
      prev = pc;
    end
    @(negedge clk);
    @(negedge clk);
    chk("seq_pulses", pulses - p0, 8);

    // Reset pulsed while the ACS counter is 2.
    do_reset(1'b0);
    n = 0;
    @(negedge clk);
    while (!sym_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    sym_valid = 1'b1;
    sym = 2'b11;
    @(posedge clk);
    #1 sym_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    chk("mid_ready", sym_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    p0 = pulses;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pm", pm, 8'hFC);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_no_pulse", pulses - p0, 0);
    run_sym(2'b00, 4'b0000, 8'hEC, 2'd0, "post_abort", pc);

    // i_sym_valid held high: one accept every 7 cycles, and ready only while idle.
    do_reset(1'b0);
    n = 0;
    @(negedge clk);
    while (!sym_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    p0 = pulses;
    sym = 2'b00;
    sym_valid = 1'b1;
    acc = 0;
    bad = 0;
    for (int i = 0; i < 21; i++) begin
      if (sym_ready && sym_valid) acc++;
      if (sym_ready && busy) bad++;
      @(negedge clk);
    end
    sym_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("stream_accepts", acc, 3);
    chk("stream_ready_busy", bad, 0);
    chk("stream_pulses", pulses - p0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
